// File: rtl/i2cio.sv
// Byte-level I2C master on the CPU bus: START / byte write / byte read / STOP
// sequences driven from CTRL writes, with ACK status, RX data and interrupt.
module i2cio #(
   parameter logic [15:0] DEFAULT_PRESCALE = 16'd29
) (
   input  logic       clk,
   input  logic       rst,
   output logic       irq,
   input  logic [2:0] AD,
   input  logic [7:0] DI,
   output logic [7:0] DO,
   input  logic       rw,
   input  logic       cs,
   inout  wire        i2c_scl,
   inout  wire        i2c_sda
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

   state_t      state_q, state_d;
   logic [15:0] prescale_q, qcnt_q;
   logic [1:0]  quarter_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  tx_data_q, rx_data_q, shift_q;
   logic        rx_bit_q, ack_in_q;
   logic        cmd_stop_q, cmd_write_q, cmd_read_q, cmd_nack_q;
   logic        ien_q, done_q, rxnack_q, held_scl_q, held_sda_q;
   logic        busy, ctrl_wr, cmd_go, data_rd;
   logic        scl_low, sda_low, hold, tick, phase_end, finish;
   logic        unused_ad;

   assign unused_ad = AD[2];
   assign busy      = (state_q != S_IDLE);
   assign ctrl_wr   = cs & ~rw & (AD[1:0] == 2'd1);
   assign cmd_go    = ctrl_wr & ~busy & (|DI[3:0]);
   assign data_rd   = cs & rw & (AD[1:0] == 2'd0);
   // A released SCL that still reads low is a slave stretching the clock.
   assign hold      = busy & ~scl_low & ~i2c_scl;
   assign tick      = busy & ~hold & (qcnt_q == prescale_q);
   assign phase_end = tick & (quarter_q == 2'd3);

   assign i2c_scl = scl_low ? 1'b0 : 1'bz;
   assign i2c_sda = sda_low ? 1'b0 : 1'bz;
   assign irq     = done_q & ien_q;

   always_comb begin
      scl_low = 1'b0;
      sda_low = 1'b0;
      case (state_q)
         S_IDLE: begin
            scl_low = held_scl_q;
            sda_low = held_sda_q;
         end
         S_START: begin
            scl_low = (quarter_q == 2'd3);
            sda_low = (quarter_q != 2'd0);
         end
         S_BIT: begin
            scl_low = (quarter_q == 2'd0) | (quarter_q == 2'd3);
            sda_low = cmd_write_q & ~shift_q[7];
         end
         S_ACK: begin
            scl_low = (quarter_q == 2'd0) | (quarter_q == 2'd3);
            sda_low = cmd_read_q & ~cmd_nack_q;
         end
         S_STOP: begin
            scl_low = (quarter_q == 2'd0);
            sda_low = (quarter_q == 2'd0) | (quarter_q == 2'd1);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      finish  = 1'b0;
      if (cmd_go) begin
         if (DI[0])              state_d = S_START;
         else if (DI[2] | DI[3]) state_d = S_BIT;
         else                    state_d = S_STOP;
      end else if (phase_end) begin
         case (state_q)
            S_START: begin
               if (cmd_write_q | cmd_read_q) state_d = S_BIT;
               else if (cmd_stop_q)          state_d = S_STOP;
               else                          state_d = S_IDLE;
            end
            S_BIT:   state_d = (bit_cnt_q == 3'd0) ? S_ACK : S_BIT;
            S_ACK:   state_d = cmd_stop_q ? S_STOP : S_IDLE;
            default: state_d = S_IDLE;
         endcase
         finish = (state_d == S_IDLE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale_q  <= DEFAULT_PRESCALE;
         qcnt_q      <= '0;
         quarter_q   <= '0;
         bit_cnt_q   <= 3'd7;
         tx_data_q   <= '0;
         rx_data_q   <= '0;
         shift_q     <= '0;
         rx_bit_q    <= 1'b0;
         ack_in_q    <= 1'b0;
         cmd_stop_q  <= 1'b0;
         cmd_write_q <= 1'b0;
         cmd_read_q  <= 1'b0;
         cmd_nack_q  <= 1'b0;
         ien_q       <= 1'b0;
         done_q      <= 1'b0;
         rxnack_q    <= 1'b0;
         held_scl_q  <= 1'b0;
         held_sda_q  <= 1'b0;
      end else begin
         if (cs & ~rw & ~busy) begin
            case (AD[1:0])
               2'd0:    tx_data_q        <= DI;
               2'd2:    prescale_q[7:0]  <= DI;
               2'd3:    prescale_q[15:8] <= DI;
               default: ;
            endcase
         end
         if (ctrl_wr) ien_q <= DI[7];
         if (ctrl_wr | data_rd) done_q <= 1'b0;

         if (cmd_go) begin
            cmd_stop_q  <= DI[1];
            cmd_write_q <= DI[2];
            cmd_read_q  <= DI[3] & ~DI[2];
            cmd_nack_q  <= DI[4];
            shift_q     <= tx_data_q;
            quarter_q   <= '0;
            qcnt_q      <= '0;
         end else if (!busy || hold || tick) begin
            qcnt_q <= '0;
         end else begin
            qcnt_q <= qcnt_q + 16'd1;
         end
         if (tick) quarter_q <= quarter_q + 2'd1;

         // SDA is sampled at the end of q2 but shifted only after q3 so the
         // outgoing bit stays on the wire for the whole bit period.
         if (tick && quarter_q == 2'd2) begin
            if (state_q == S_BIT) rx_bit_q <= i2c_sda;
            if (state_q == S_ACK) ack_in_q <= i2c_sda;
         end
         if (state_q != S_BIT) begin
            bit_cnt_q <= 3'd7;
         end else if (phase_end) begin
            bit_cnt_q <= bit_cnt_q - 3'd1;
            shift_q   <= {shift_q[6:0], rx_bit_q};
         end

         if (finish) begin
            done_q     <= 1'b1;
            held_scl_q <= scl_low;
            held_sda_q <= sda_low;
            if (cmd_write_q) rxnack_q  <= ack_in_q;
            if (cmd_read_q)  rx_data_q <= shift_q;
         end
      end
   end

   always_comb begin
      DO = 8'h00;
      case (AD[1:0])
         2'd0: DO = rx_data_q;
         2'd1: DO = {ien_q, done_q, 4'b0000, rxnack_q, busy};
         2'd2: DO = prescale_q[7:0];
         2'd3: DO = prescale_q[15:8];
         default: ;
      endcase
   end

endmodule

// File: tb/tb_i2cio.sv
// Directed bench for i2cio: pulled-up open-drain bus with a scripted slave.
module tb_i2cio;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       irq;
   logic [2:0] AD = 3'd0;
   logic [7:0] DI = 8'h00;
   logic [7:0] DO;
   logic       rw = 1'b1;
   logic       cs = 1'b0;
   wire        scl_bus, sda_bus;
   logic       slave_scl_low = 1'b0;
   logic       slave_sda_low = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int e0 = 0;

   pullup (scl_bus);
   pullup (sda_bus);
   assign scl_bus = slave_scl_low ? 1'b0 : 1'bz;
   assign sda_bus = slave_sda_low ? 1'b0 : 1'bz;

   i2cio dut (
      .clk     (clk),
      .rst     (rst),
      .irq     (irq),
      .AD      (AD),
      .DI      (DI),
      .DO      (DO),
      .rw      (rw),
      .cs      (cs),
      .i2c_scl (scl_bus),
      .i2c_sda (sda_bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
      cs = 1'b1; rw = 1'b0; AD = a; DI = d;
      @(posedge clk); #1;
      cs = 1'b0; rw = 1'b1;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [7:0] v);
      cs = 1'b1; rw = 1'b1; AD = a;
      #1 v = DO;
      @(posedge clk); #1;
      cs = 1'b0;
   endtask

   task automatic peek(input logic [2:0] a, output logic [7:0] v);
      cs = 1'b1; rw = 1'b1; AD = a;
      #1 v = DO;
      cs = 1'b0;
   endtask

   task automatic go_to(input int n);
      while (cyc - e0 < n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] b;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      peek(3'd1, v); check("rst_status", v, 8'h00);
      peek(3'd2, v); check("rst_presc_lo", v, 8'h1D);
      peek(3'd3, v); check("rst_presc_hi", v, 8'h00);
      peek(3'd0, v); check("rst_data", v, 8'h00);
      check("rst_scl", scl_bus, 1'b1);
      check("rst_sda", sda_bus, 1'b1);
      check("rst_irq", irq, 1'b0);

      // Write 0xA5 with START|STOP|WRITE|IEN, slave ACKs
      bus_wr(3'd0, 8'hA5);
      bus_wr(3'd1, 8'h87);
      e0 = cyc;
      peek(3'd1, v); check("t1_busy_start", v, 8'h81);
      b = 8'hA5;
      for (int k = 0; k < 8; k++) begin
         go_to(30 * (6 + 4 * k) + 15);
         check($sformatf("t1_bit%0d", k), sda_bus, b[7 - k]);
      end
      go_to(1080); slave_sda_low = 1'b1;
      go_to(1200); slave_sda_low = 1'b0;
      go_to(1319); peek(3'd1, v); check("t1_busy_end", v, 8'h81);
      go_to(1320); peek(3'd1, v); check("t1_done", v, 8'hC0);
      check("t1_irq", irq, 1'b1);
      check("t1_bus_free", {scl_bus, sda_bus}, 2'b11);
      bus_rd(3'd0, v); check("t1_data", v, 8'h00);
      check("t1_irq_clr", irq, 1'b0);

      // Same write, nobody answers
      bus_wr(3'd1, 8'h87);
      e0 = cyc;
      go_to(1320); peek(3'd1, v); check("t2_rxnack", v, 8'hC2);
      check("t2_irq", irq, 1'b1);

      // PRESCALE=0, READ|STOP|NACK, slave sends 0x3C
      bus_wr(3'd2, 8'h00);
      bus_wr(3'd1, 8'h1A);
      e0 = cyc;
      check("t3_irq_off", irq, 1'b0);
      b = 8'h3C;
      for (int k = 0; k < 8; k++) begin
         go_to(4 * k);
         slave_sda_low = ~b[7 - k];
      end
      go_to(32); slave_sda_low = 1'b0;
      go_to(33); check("t3_ack_sda", sda_bus, 1'b1);
      go_to(39); peek(3'd1, v); check("t3_busy_end", v & 8'h41, 8'h01);
      go_to(40); peek(3'd1, v); check("t3_done", v & 8'h41, 8'h40);
      bus_rd(3'd0, v); check("t3_rx", v, 8'h3C);

      // PRESCALE=3, 0x5A write with 100-cycle stretch in q1 of bit 3
      bus_wr(3'd2, 8'h03);
      bus_wr(3'd0, 8'h5A);
      bus_wr(3'd1, 8'h07);
      e0 = cyc;
      b = 8'h5A;
      for (int k = 0; k < 8; k++) begin
         if (k == 3) begin
            go_to(66);  slave_scl_low = 1'b1;
            go_to(168); slave_scl_low = 1'b0;
         end
         go_to(4 * (6 + 4 * k) + 2 + ((k >= 3) ? 100 : 0));
         check($sformatf("t4_bit%0d", k), sda_bus, b[7 - k]);
      end
      go_to(275); peek(3'd1, v); check("t4_busy_end", v & 8'h41, 8'h01);
      go_to(276); peek(3'd1, v); check("t4_done", v & 8'h41, 8'h40);

      // Writes while busy, then reset mid-byte
      bus_wr(3'd0, 8'hC3);
      bus_wr(3'd1, 8'h07);
      e0 = cyc;
      go_to(10);
      bus_wr(3'd0, 8'h11);
      bus_wr(3'd2, 8'h00);
      bus_wr(3'd1, 8'h80);
      peek(3'd1, v); check("t5_ien_busy", v, 8'h83);
      peek(3'd2, v); check("t5_presc_keep", v, 8'h03);
      check("t5_irq", irq, 1'b0);
      b = 8'hC3;
      for (int k = 0; k < 4; k++) begin
         go_to(4 * (6 + 4 * k) + 2);
         check($sformatf("t5_bit%0d", k), sda_bus, b[7 - k]);
      end
      go_to(80);
      rst = 1'b1;
      #1 check("t5_rst_pins", {scl_bus, sda_bus}, 2'b11);
      @(posedge clk); #1 rst = 1'b0;
      peek(3'd1, v); check("t5_rst_status", v, 8'h00);
      peek(3'd2, v); check("t5_rst_presc", v, 8'h1D);
      check("t5_rst_irq", irq, 1'b0);
      @(posedge clk); #1;
      check("t5_idle_pins", {scl_bus, sda_bus}, 2'b11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
